// File: rtl/uart_rx_v_2.sv
// UART receiver: 2-FF input synchronizer, mid-bit sampling FSM and
// valid/ack word handshake. Reports framing errors and overruns.
module uart_rx_v_2 #(
    parameter int CLKRATE     = 1000000,
    parameter int BAUD        = 9600,
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   UART_Rx_IN,
    input  logic                   UART_Rx_ACK,
    output logic [WORD_LENGTH-1:0] Rx_DATA,
    output logic                   UART_Rx_VALID,
    output logic                   UART_Rx_FRAME_ERR,
    output logic                   UART_Rx_OVERRUN,
    output logic                   UART_Rx_BUSY
);
    localparam int BAUD_COUNTER_MAX  = CLKRATE / BAUD;
    localparam int HALF_BIT          = BAUD_COUNTER_MAX / 2;
    localparam int BAUD_COUNTER_SIZE = $clog2(BAUD_COUNTER_MAX);
    localparam int DATA_COUNTER_SIZE = $clog2(WORD_LENGTH + 1);

    localparam logic [BAUD_COUNTER_SIZE-1:0] BAUD_LAST = BAUD_COUNTER_SIZE'(BAUD_COUNTER_MAX - 1);
    localparam logic [BAUD_COUNTER_SIZE-1:0] HALF_LAST = BAUD_COUNTER_SIZE'(HALF_BIT - 1);
    localparam logic [BAUD_COUNTER_SIZE-1:0] BAUD_ZERO = '0;
    localparam logic [BAUD_COUNTER_SIZE-1:0] BAUD_ONE  = BAUD_COUNTER_SIZE'(1);
    localparam logic [DATA_COUNTER_SIZE-1:0] BITS_LAST = DATA_COUNTER_SIZE'(WORD_LENGTH - 1);
    localparam logic [DATA_COUNTER_SIZE-1:0] BITS_ZERO = '0;
    localparam logic [DATA_COUNTER_SIZE-1:0] BITS_ONE  = DATA_COUNTER_SIZE'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic                          r_sync1;
    logic                          r_rx_s;
    logic [BAUD_COUNTER_SIZE-1:0]  r_baud_cnt;
    logic [BAUD_COUNTER_SIZE-1:0]  w_baud_next;
    logic [DATA_COUNTER_SIZE-1:0]  r_bit_cnt;
    logic [DATA_COUNTER_SIZE-1:0]  w_bit_next;
    logic [WORD_LENGTH-1:0]        r_shift;
    logic [WORD_LENGTH-1:0]        w_shift_next;
    logic                          w_good_stop;
    logic                          w_bad_stop;
    logic [WORD_LENGTH-1:0]        r_data;
    logic                          r_valid;
    logic                          r_frame_err;
    logic                          r_overrun;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= UART_Rx_IN;
            r_rx_s  <= r_sync1;
        end
    end

    // FSM state, baud/bit counters and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
        end
    end

    // Next-state logic: half-bit start qualification, then full-bit sampling
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_good_stop  = 1'b0;
        w_bad_stop   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = START;
                    w_baud_next  = BAUD_ZERO;
                end
            end
            START: begin
                if (r_baud_cnt == HALF_LAST) begin
                    w_baud_next = BAUD_ZERO;
                    w_bit_next  = BITS_ZERO;
                    // A start bit gone high by mid-bit is a glitch: drop it quietly
                    w_state_next = r_rx_s ? IDLE : DATA;
                end else begin
                    w_baud_next = r_baud_cnt + BAUD_ONE;
                end
            end
            DATA: begin
                if (r_baud_cnt == BAUD_LAST) begin
                    w_baud_next  = BAUD_ZERO;
                    w_shift_next = {r_rx_s, r_shift[WORD_LENGTH-1:1]};
                    w_bit_next   = r_bit_cnt + BITS_ONE;
                    if (r_bit_cnt == BITS_LAST) begin
                        w_state_next = STOP;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + BAUD_ONE;
                end
            end
            STOP: begin
                if (r_baud_cnt == BAUD_LAST) begin
                    w_baud_next = BAUD_ZERO;
                    if (r_rx_s) begin
                        // Leave mid stop bit so a back-to-back start edge is not missed
                        w_good_stop  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_bad_stop   = 1'b1;
                        w_state_next = WAIT_HIGH;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + BAUD_ONE;
                end
            end
            WAIT_HIGH: begin
                // A held-low break must not retrigger, so wait for the line to recover
                if (r_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_baud_next  = BAUD_ZERO;
                w_bit_next   = BITS_ZERO;
            end
        endcase
    end

    // Word handshake: deliver good frames, track overruns, one-cycle frame error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            if (w_good_stop) begin
                if (!r_valid || UART_Rx_ACK) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (UART_Rx_ACK && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign Rx_DATA           = r_data;
    assign UART_Rx_VALID     = r_valid;
    assign UART_Rx_FRAME_ERR = r_frame_err;
    assign UART_Rx_OVERRUN   = r_overrun;
    assign UART_Rx_BUSY      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_v_2.sv
// Self-checking bench for uart_rx_v_2: serial frames are generated here,
// expected words go into a scoreboard queue and are popped on delivery.
module tb_uart_rx_v_2;
    localparam int BIT = 104;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int rise_cnt = 0;
    int rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_v_2 #(.CLKRATE(1000000), .BAUD(9600), .WORD_LENGTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .UART_Rx_IN       (rx_in),
        .UART_Rx_ACK      (ack),
        .Rx_DATA          (rx_data),
        .UART_Rx_VALID    (rx_valid),
        .UART_Rx_FRAME_ERR(frame_err),
        .UART_Rx_OVERRUN  (overrun),
        .UART_Rx_BUSY     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event monitor on the falling edge: frame-error pulses and VALID rises
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        prev_valid = rx_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (BIT) tick();
    endtask

    // Start, 8 data bits LSB first, stop bit; the line is left at the stop value
    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_v);
    endtask

    // Bounded wait for VALID, then pop the scoreboard and compare the word
    task automatic expect_word(input string name);
        logic [7:0] exp;
        int budget;
        budget = 0;
        while (rx_valid !== 1'b1 && budget < 300) begin
            tick();
            budget++;
        end
        n_vec++;
        if (rx_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_valid_timeout: VALID=%b after %0d cycles, required 1", name, rx_valid, budget);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_scoreboard: queue empty, got data %h", name, rx_data);
        end else begin
            exp = exp_q.pop_front();
            if (rx_data !== exp) begin
                n_err++;
                $display("FAIL %s_data: got %h, required %h", name, rx_data, exp);
            end else begin
                $display("rx %s: word %h", name, rx_data);
            end
        end
    endtask

    task automatic test_reset();
        int viol;
        rst = 1'b1;
        rx_in = 1'b1;
        ack = 1'b0;
        repeat (10) tick();
        n_vec++;
        if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b, required all 0",
                     rx_data, rx_valid, frame_err, overrun, busy);
        end
        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) viol++;
        end
        n_vec++;
        if (viol !== 0) begin
            n_err++;
            $display("FAIL idle_quiet: %0d cycles with nonzero outputs, required 0", viol);
        end
        $display("reset: idle 1000 cycles done");
    endtask

    task automatic test_good_frame();
        int fe0, r0, t0, lat;
        fe0 = fe_cnt;
        r0 = rise_cnt;
        t0 = cyc;
        exp_q.push_back(8'h56);
        send_frame(8'h56, 1'b1);
        expect_word("good_56");
        lat = rise_cyc - (t0 + 1);
        n_vec++;
        if (lat < 990 || lat > 992) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, required 991 +/-1", lat);
        end
        n_vec++;
        if (rise_cnt - r0 !== 1) begin
            n_err++;
            $display("FAIL valid_rises: got %0d, required 1", rise_cnt - r0);
        end
        n_vec++;
        if (fe_cnt - fe0 !== 0) begin
            n_err++;
            $display("FAIL good_no_fe: got %0d pulses, required 0", fe_cnt - fe0);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_vec++;
        if (rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ack_clears_valid: got %b, required 0", rx_valid);
        end
        n_vec++;
        if (rx_data !== 8'h56) begin
            n_err++;
            $display("FAIL ack_keeps_data: got %h, required 56", rx_data);
        end
    endtask

    task automatic test_glitch();
        int fe0, nbusy;
        fe0 = fe_cnt;
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            rx_in = (i < 20) ? 1'b0 : 1'b1;
            tick();
            if (busy === 1'b1) nbusy++;
        end
        n_vec++;
        if (nbusy < 20 || nbusy > 60) begin
            n_err++;
            $display("FAIL glitch_busy_len: got %0d cycles, required 20..60", nbusy);
        end
        n_vec++;
        if ({busy, rx_valid, rx_data, overrun} !== {1'b0, 1'b0, 8'h56, 1'b0} || fe_cnt != fe0) begin
            n_err++;
            $display("FAIL glitch_silent: busy=%b v=%b data=%h ov=%b fe_pulses=%0d, required 0 0 56 0 0",
                     busy, rx_valid, rx_data, overrun, fe_cnt - fe0);
        end
        $display("glitch: busy %0d cycles", nbusy);
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (500) tick();
        n_vec++;
        if (fe_cnt - fe0 !== 1) begin
            n_err++;
            $display("FAIL fe_pulse_count: got %0d, required 1", fe_cnt - fe0);
        end
        n_vec++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h56) begin
            n_err++;
            $display("FAIL fe_no_delivery: v=%b data=%h, required 0 56", rx_valid, rx_data);
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL fe_busy_low: got %b, required 1", busy);
        end
        rx_in = 1'b1;
        repeat (5) tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL fe_busy_release: got %b, required 0", busy);
        end
        $display("frame_err: 3C with bad stop, %0d pulse(s)", fe_cnt - fe0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        expect_word("after_fe_81");
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        expect_word("overrun_keep_A5");
        n_vec++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_vec++;
        if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ack_clears_overrun: v=%b ov=%b, required 0 0", rx_valid, overrun);
        end
    endtask

    task automatic test_ack_coincident();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        exp_q.push_back(8'h3C);
        fork
            send_frame(8'h3C, 1'b1);
            begin
                // Second delivery lands on the 991st edge after the start bit is driven
                repeat (990) tick();
                ack = 1'b1;
                tick();
                ack = 1'b0;
            end
        join
        // First word was superseded by the coincident reload
        void'(exp_q.pop_front());
        expect_word("coincident_3C");
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL coincident_no_overrun: got %b, required 0", overrun);
        end
    endtask

    task automatic test_reset_midframe();
        int fe0;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (5 * BIT + 50) tick();
                #2;
                rst = 1'b1;
                #1;
                n_vec++;
                if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
                    n_err++;
                    $display("FAIL async_reset: data=%h v=%b fe=%b ov=%b busy=%b, required all 0",
                             rx_data, rx_valid, frame_err, overrun, busy);
                end
                repeat (3) tick();
                rst = 1'b0;
            end
        join
        repeat (20) tick();
        n_vec++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL no_partial_word: v=%b data=%h, required 0 00", rx_valid, rx_data);
        end
        fe0 = fe_cnt;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        expect_word("after_reset_FF");
        n_vec++;
        if (overrun !== 1'b0 || fe_cnt != fe0) begin
            n_err++;
            $display("FAIL after_reset_flags: ov=%b fe_pulses=%0d, required 0 0", overrun, fe_cnt - fe0);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx_in = 1'b1;
        ack = 1'b0;
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_ack_coincident();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
